// File: rtl/key_debounce_n_pkg.sv
// Shared types and default constants for the multi-key debouncer.
package key_pkg;

    // Per-channel hold state: released, held, held past the long-press point.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } key_st_t;

    localparam int KEY_N_KEYS_DEF        = 5;
    localparam bit KEY_ACTIVE_LOW_DEF    = 1'b1;
    localparam int KEY_DB_CYCLES_DEF     = 20;
    localparam int KEY_LONG_CYCLES_DEF   = 1000;
    localparam int KEY_REPEAT_CYCLES_DEF = 200;

endpackage

// File: rtl/key_debounce_n_if.sv
// Bundle of raw key pins, repeat enable and the debounced event outputs.
interface key_debounce_n_if #(
    parameter int N_KEYS = 5
);
    logic [N_KEYS-1:0] key;
    logic              repeat_en;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    // Board / control side: drives pins, consumes events.
    modport master (
        output key, repeat_en,
        input  key_level, key_press, key_release, key_long, key_repeat
    );

    // Debouncer side.
    modport slave (
        input  key, repeat_en,
        output key_level, key_press, key_release, key_long, key_repeat
    );
endinterface

// File: rtl/key_debounce_n_ch.sv
// One key channel: 2-flop synchroniser, stability counter and hold FSM.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW    = KEY_ACTIVE_LOW_DEF,
    parameter int DB_CYCLES     = KEY_DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = KEY_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam int HW  = $clog2(LONG_CYCLES);
    localparam int RW  = $clog2(REPEAT_CYCLES);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic           sync1, sync2;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [RW-1:0]  rep_cnt;
    key_st_t        st;

    logic p, diff, accept, acc_press, acc_rel;

    // Qualification decode: a level change is accepted on the edge where the
    // counter sits at its last value and the sample still disagrees.
    always_comb begin
        p         = sync2 ^ ACTIVE_LOW;
        diff      = (p != key_level);
        accept    = diff && (db_cnt == DB_LAST);
        acc_press = accept && !key_level;
        acc_rel   = accept && key_level;
    end

    // Two-flop synchroniser, parked at the idle pin level during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Stability counter and debounced level with press/release pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= acc_press;
            key_release <= acc_rel;
            if (!diff || accept) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
            if (accept) begin
                key_level <= ~key_level;
            end
        end
    end

    // Hold FSM: long-press and auto-repeat; an accepted release wins over
    // any long/repeat pulse due on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            key_long   <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            key_long   <= 1'b0;
            key_repeat <= 1'b0;
            if (acc_rel) begin
                st       <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        if (acc_press) begin
                            st       <= DOWN;
                            hold_cnt <= '0;
                        end
                    end
                    DOWN: begin
                        if (hold_cnt == HOLD_LAST) begin
                            key_long <= 1'b1;
                            st       <= LONG;
                            hold_cnt <= '0;
                            rep_cnt  <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    LONG: begin
                        if (!repeat_en) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_LAST) begin
                            key_repeat <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
                    end
                    default: begin
                        st       <= IDLE;
                        hold_cnt <= '0;
                        rep_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_debounce_n.sv
// Multi-key debouncer top: N_KEYS fully independent channels.
module key_debounce_n
    import key_pkg::*;
#(
    parameter int N_KEYS        = KEY_N_KEYS_DEF,
    parameter bit ACTIVE_LOW    = KEY_ACTIVE_LOW_DEF,
    parameter int DB_CYCLES     = KEY_DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = KEY_LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    key_debounce_n_if.slave  bus
);
    logic [N_KEYS-1:0] lvl_v, prs_v, rel_v, lng_v, rep_v;

    // One channel per key; repeat_en is shared by all of them.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DB_CYCLES     (DB_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key         (bus.key[i]),
            .repeat_en   (bus.repeat_en),
            .key_level   (lvl_v[i]),
            .key_press   (prs_v[i]),
            .key_release (rel_v[i]),
            .key_long    (lng_v[i]),
            .key_repeat  (rep_v[i])
        );
    end

    assign bus.key_level   = lvl_v;
    assign bus.key_press   = prs_v;
    assign bus.key_release = rel_v;
    assign bus.key_long    = lng_v;
    assign bus.key_repeat  = rep_v;

endmodule

// File: tb/tb_key_debounce_n.sv
// Directed bench for key_debounce_n with default parameters.
module tb_key_debounce_n;
    logic clk = 1'b0;
    logic rst_n;

    key_debounce_n_if #(.N_KEYS(5)) bus ();

    key_debounce_n #(
        .N_KEYS(5), .ACTIVE_LOW(1'b1), .DB_CYCLES(20),
        .LONG_CYCLES(1000), .REPEAT_CYCLES(200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // event kinds: 0 press, 1 release, 2 long, 3 repeat
    int ev_n[4][5];
    int ev_first[4][5];
    int ev_last[4][5];

    // Edge counter and pulse log, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        logic [4:0] sig;
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: sig = bus.key_press;
                1: sig = bus.key_release;
                2: sig = bus.key_long;
                default: sig = bus.key_repeat;
            endcase
            for (int c = 0; c < 5; c++) begin
                if (sig[c]) begin
                    if (ev_n[k][c] == 0) ev_first[k][c] = cyc;
                    ev_last[k][c] = cyc;
                    ev_n[k][c]++;
                end
            end
        end
    end

    task automatic clr();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 5; c++) begin
                ev_n[k][c] = 0; ev_first[k][c] = -1; ev_last[k][c] = -1;
            end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_to(input int e);
        if (e > cyc) tick(e - cyc);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic int mask_of(input int k);
        int m = 0;
        for (int c = 0; c < 5; c++) if (ev_n[k][c] != 0) m |= (1 << c);
        return m;
    endfunction

    function automatic int sum_of(input int k);
        int s = 0;
        for (int c = 0; c < 5; c++) s += ev_n[k][c];
        return s;
    endfunction

    typedef struct {
        logic [4:0] key;
        int         ncyc;
        logic [4:0] lvl;
        logic [4:0] prs;
        logic [4:0] rel;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e0, p;
        string nm;

        tbl[0] = '{5'b11111, 50, 5'b00000, 5'b00000, 5'b00000};
        tbl[1] = '{5'b11110, 30, 5'b00001, 5'b00001, 5'b00000};
        tbl[2] = '{5'b10100, 30, 5'b01011, 5'b01010, 5'b00000};
        tbl[3] = '{5'b11111, 30, 5'b00000, 5'b00000, 5'b01011};
        tbl[4] = '{5'b01111, 30, 5'b10000, 5'b10000, 5'b00000};
        tbl[5] = '{5'b11111, 30, 5'b00000, 5'b00000, 5'b10000};
        tbl[6] = '{5'b11011, 10, 5'b00000, 5'b00000, 5'b00000};
        tbl[7] = '{5'b11111, 30, 5'b00000, 5'b00000, 5'b00000};

        rst_n = 1'b0;
        bus.key = 5'b11111;
        bus.repeat_en = 1'b1;
        clr();
        tick(3);
        chk("reset_level", int'(bus.key_level), 0);
        chk("reset_pulses", int'(bus.key_press | bus.key_release | bus.key_long | bus.key_repeat), 0);
        rst_n = 1'b1;

        // ---- table-driven level / press / release vectors
        for (int i = 0; i < 8; i++) begin
            clr();
            bus.key = tbl[i].key;
            tick(tbl[i].ncyc);
            $sformat(nm, "tbl%0d_level", i);
            chk(nm, int'(bus.key_level), int'(tbl[i].lvl));
            $sformat(nm, "tbl%0d_press", i);
            chk(nm, mask_of(0), int'(tbl[i].prs));
            chk({nm, "_cnt"}, sum_of(0), $countones(tbl[i].prs));
            $sformat(nm, "tbl%0d_release", i);
            chk(nm, mask_of(1), int'(tbl[i].rel));
            chk({nm, "_cnt"}, sum_of(1), $countones(tbl[i].rel));
            $sformat(nm, "tbl%0d_longrep", i);
            chk(nm, sum_of(2) + sum_of(3), 0);
        end

        // ---- clean press / release on key 2
        clr();
        bus.key[2] = 1'b0;
        e0 = cyc + 1;
        tick_to(e0 + 40);
        chk("k2_press_edge", ev_first[0][2], e0 + 21);
        chk("k2_press_cnt", ev_n[0][2], 1);
        chk("k2_level", int'(bus.key_level[2]), 1);
        tick_to(e0 + 489);
        bus.key[2] = 1'b1;
        tick_to(e0 + 530);
        chk("k2_release_edge", ev_first[1][2], e0 + 490 + 21);
        chk("k2_level_off", int'(bus.key_level[2]), 0);

        // ---- bounce on key 0
        clr();
        e0 = 0;
        for (int i = 0; i <= 40; i++) begin
            bus.key[0] = (i == 40) ? 1'b0 : (((i / 3) % 2) == 0 ? 1'b0 : 1'b1);
            if (i == 40) e0 = cyc + 1;
            tick(1);
        end
        tick(40);
        chk("bounce_press_cnt", ev_n[0][0], 1);
        chk("bounce_press_edge", ev_first[0][0], e0 + 21);
        chk("bounce_release_cnt", ev_n[1][0], 0);
        bus.key[0] = 1'b1;
        tick(30);

        // ---- long press with auto-repeat on key 4
        clr();
        bus.repeat_en = 1'b1;
        bus.key[4] = 1'b0;
        p = cyc + 1 + 21;
        tick_to(p + 1550);
        chk("k4_press_edge", ev_first[0][4], p);
        chk("k4_long_cnt", ev_n[2][4], 1);
        chk("k4_long_edge", ev_first[2][4], p + 1000);
        chk("k4_rep_cnt", ev_n[3][4], 2);
        chk("k4_rep1_edge", ev_first[3][4], p + 1200);
        chk("k4_rep2_edge", ev_last[3][4], p + 1400);
        bus.key[4] = 1'b1;
        tick(30);
        chk("k4_release_cnt", ev_n[1][4], 1);
        chk("k4_rep_after_rel", ev_n[3][4], 2);

        // ---- long press with repeat disabled, then enabled late
        clr();
        bus.repeat_en = 1'b0;
        bus.key[4] = 1'b0;
        p = cyc + 1 + 21;
        tick_to(p + 1300);
        chk("k4n_long_edge", ev_first[2][4], p + 1000);
        chk("k4n_rep_none", ev_n[3][4], 0);
        bus.repeat_en = 1'b1;
        tick_to(p + 1550);
        chk("k4n_rep_cnt", ev_n[3][4], 1);
        chk("k4n_rep_edge", ev_first[3][4], p + 1500);
        chk("k4n_long_cnt", ev_n[2][4], 1);
        bus.key[4] = 1'b1;
        tick(30);

        // ---- keys 1 and 3 together, key 1 released early
        clr();
        bus.key[1] = 1'b0;
        bus.key[3] = 1'b0;
        p = cyc + 1 + 21;
        tick_to(p + 300);
        bus.key[1] = 1'b1;
        tick_to(p + 1050);
        chk("k13_press_same", ev_first[0][1], ev_first[0][3]);
        chk("k1_release_edge", ev_first[1][1], p + 301 + 21);
        chk("k1_long_none", ev_n[2][1], 0);
        chk("k3_long_edge", ev_first[2][3], p + 1000);
        chk("k3_level", int'(bus.key_level[3]), 1);
        bus.key[3] = 1'b1;
        tick(30);

        // ---- key 1 release accepted at P+999: no long
        clr();
        bus.key[1] = 1'b0;
        p = cyc + 1 + 21;
        tick_to(p + 977);
        bus.key[1] = 1'b1;
        tick_to(p + 1020);
        chk("k1_999_release_edge", ev_first[1][1], p + 999);
        chk("k1_999_long_none", ev_n[2][1], 0);

        // ---- key 2 release accepted at P+1000, same edge as long: release wins
        clr();
        bus.key[2] = 1'b0;
        p = cyc + 1 + 21;
        tick_to(p + 978);
        bus.key[2] = 1'b1;
        tick_to(p + 1020);
        chk("k2_1000_release_edge", ev_first[1][2], p + 1000);
        chk("k2_1000_long_none", ev_n[2][2], 0);
        chk("k2_1000_level", int'(bus.key_level[2]), 0);

        // ---- asynchronous reset mid-press
        clr();
        bus.key[2] = 1'b0;
        tick(30);
        chk("rst_pre_level", int'(bus.key_level[2]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_level", int'(bus.key_level), 0);
        tick(2);
        clr();
        rst_n = 1'b1;
        e0 = cyc + 1;
        tick(40);
        chk("rst_repress_edge", ev_first[0][2], e0 + 21);
        chk("rst_no_release", ev_n[1][2], 0);
        bus.key[2] = 1'b1;
        tick(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce_n.md
# key_debounce_n

Parametrised multi-key debouncer with press/release edge pulses, long-press detection and auto-repeat. Each of `N_KEYS` channels has its own synchroniser, its own stability counter and its own hold state machine, so keys never share timing. It sits between the board push-buttons and the control/menu logic, on the 1 kHz system tick clock. It replaces single-counter debouncing, where one key's edge restarts timing for all keys.

## Interface
- `N_KEYS`, 5: number of independent key channels.
- `ACTIVE_LOW`, 1: 1 means a pressed key reads 0 at the pin. Idle pin level is `ACTIVE_LOW`.
- `DB_CYCLES`, 20: consecutive stable cycles needed to accept a level change. Must be ≥2.
- `LONG_CYCLES`, 1000: cycles from the press pulse to the long-press pulse. Must be ≥2.
- `REPEAT_CYCLES`, 200: auto-repeat period after long press. Must be ≥2.
- `clk` in 1: system clock, 1 kHz in current design; all registers on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `key` in N_KEYS: raw, asynchronous pin levels.
- `repeat_en` in 1: global enable for auto-repeat pulses.
- `key_level` out N_KEYS: debounced pressed state, 1 = pressed, polarity-normalised.
- `key_press` out N_KEYS: 1-cycle pulse on accepted press.
- `key_release` out N_KEYS: 1-cycle pulse on accepted release.
- `key_long` out N_KEYS: 1-cycle pulse, at most once per press.
- `key_repeat` out N_KEYS: 1-cycle pulse every `REPEAT_CYCLES` while held past long press, only while `repeat_en` is high.

## Operation
- **Reset** (async, `rst_n`=0):
  - Synchroniser flops are set to the idle pin level (`ACTIVE_LOW`).
  - All counters go to 0 and every channel FSM goes to IDLE.
  - Every output is 0.
- **Synchroniser:** two flops per bit. Normalised sample `p = sync2 ^ ACTIVE_LOW`.
- **Stability counter** `db_cnt`, width `$clog2(DB_CYCLES)`:
  - If `p == key_level`, clear to 0.
  - Otherwise increment.
  - When it reaches `DB_CYCLES-1` and `p` still differs, on that edge: toggle `key_level`, clear `db_cnt`, and assert `key_press` (new level 1) or `key_release` (new level 0).
  - A single matching cycle mid-count (glitch) restarts qualification from 0.
- **Hold FSM** per channel, states IDLE, DOWN, LONG:
  - IDLE → DOWN on accepted press; `hold_cnt`=0.
  - In DOWN, `hold_cnt` increments every cycle. At `hold_cnt == LONG_CYCLES-1`: pulse `key_long`, go to LONG, `rep_cnt`=0.
  - In LONG with `repeat_en`=1, `rep_cnt` increments. At `REPEAT_CYCLES-1`: pulse `key_repeat`, `rep_cnt`=0.
  - In LONG with `repeat_en`=0, `rep_cnt` holds at 0.
  - Accepted release in any state → IDLE, counters cleared.
  - The release takes priority over a `key_long` or `key_repeat` due on the same edge; neither fires.
- **Counter widths:** `hold_cnt` is `$clog2(LONG_CYCLES)` bits, `rep_cnt` is `$clog2(REPEAT_CYCLES)` bits. Neither counter wraps, because each is cleared on its terminal count.
- **Channel independence:** channels never interact. Simultaneous events on several channels produce simultaneous pulses.

## Timing
- The pin changes and is first sampled at edge e0 and stays stable. `key_level` and `key_press`/`key_release` update at edge e0+`DB_CYCLES`+1.
- `key_long` is asserted at edge P+`LONG_CYCLES`, where P is the `key_press` edge.
- With `repeat_en` held at 1, the k-th `key_repeat` is asserted at edge P+`LONG_CYCLES`+k·`REPEAT_CYCLES`.
- When `repeat_en` rises in LONG, the first repeat comes `REPEAT_CYCLES` edges later.
- All outputs are registered; each pulse is exactly one cycle wide.
- Reset mid-press: after `rst_n` deasserts with the key still held, the channel qualifies a fresh press (press pulse at `DB_CYCLES`+1 edges after the first post-reset sampling edge). No release pulse is generated.

## Structure
- Package `key_pkg`: FSM state enum `key_st_t` (IDLE, DOWN, LONG) and default parameter constants.
- Sub-module `key_debounce_ch`: one channel (synchroniser, `db_cnt`, hold FSM), scalar ports.
- The top instantiates `N_KEYS` copies via generate and fans out `repeat_en`.

## Test plan
All cases use defaults (5 keys, active-low, DB 20, LONG 1000, REPEAT 200).
- Reset, all keys high: hold 50 cycles → all outputs 0. Assert `rst_n` low mid-run → outputs 0 immediately, without waiting for a clock edge.
- Clean press of `key[2]` (driven 0) sampled at edge 10: `key_press[2]` pulses at edge 31 and `key_level[2]`=1. Release sampled at edge 500 → `key_release[2]` pulses at edge 521.
- Bounce: `key[0]` toggles every 3 cycles for 40 cycles, then settles low → exactly one `key_press[0]`, 21 edges after the first sampling edge of the final stable level.
- Hold `key[4]` for 1500 cycles with `repeat_en`=1, press pulse at P: `key_long` at P+1000, repeats at P+1200 and P+1400, no further pulses before release.
- Same hold with `repeat_en`=0 → `key_long` only, no repeats. Raise `repeat_en` at P+1300 → first repeat at P+1500.
- `key[1]` and `key[3]` pressed together, `key[1]` released after 300 cycles → `key[3]` long/level unaffected. `key[1]` release accepted at edge P+999 → `key_release` only, no `key_long`.
